// File: rtl/s3g_tx_pkg.sv
// Shared S3G framing constants and the framer state encoding.
// Also used by the receive side, so keep the constants in step with s3g_rx.
package s3g_tx_pkg;

  localparam logic [7:0] S3G_START    = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;
  localparam int         S3G_MAX_LEN  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    CRC   = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/s3g_tx_if.sv
// Byte link between the S3G framer and the UART transmitter.
interface s3g_tx_if;

  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  // Handshake: tx_wr is a one-cycle strobe with tx_data valid in that same
  // cycle; the UART answers with a one-cycle tx_done once the byte has fully
  // shifted out. At most one byte is in flight, so tx_wr never repeats
  // before the tx_done of the previous byte.
  modport master (output tx_data, output tx_wr, input tx_done);
  modport slave  (input tx_data, input tx_wr, output tx_done);

endinterface

// File: rtl/crc8_maxim.sv
// Combinational CRC8 (Maxim/iButton, reflected poly 0x8C) fold of one byte.
module crc8_maxim
  import s3g_tx_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ S3G_CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/s3g_tx.sv
// S3G response framer: serialises 0xD5, len, payload, CRC8 one byte at a time
// to the UART. Each byte is issued on the same edge that enters its state.
module s3g_tx
  import s3g_tx_pkg::*;
#(
  parameter int MAX_LEN = S3G_MAX_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       send,
  input  logic [5:0] len,
  output logic       busy,
  output logic       done,
  output logic       err,
  s3g_tx_if.master   link,
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [4:0] idx_q, idx_d, rd_idx;
  logic [7:0] crc_q, crc_d, crc_fold, rd_byte;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_wr_q, tx_wr_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       accept, last;
  logic [7:0] mem [MAX_LEN];

  // Buffer is locked for the whole frame and survives reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) mem[wr_addr] <= wr_data;
  end

  // Byte being issued next: buf[0] from LEN, buf[idx+1] while in DATA.
  assign rd_idx  = (state_q == DATA) ? idx_q + 5'd1 : 5'd0;
  assign rd_byte = mem[rd_idx];

  crc8_maxim u_crc (
    .crc_in  (crc_q),
    .data    (rd_byte),
    .crc_out (crc_fold)
  );

  // A tx_done coinciding with our own tx_wr belongs to no byte of ours.
  assign accept = link.tx_done && !tx_wr_q;
  assign last   = ({1'b0, idx_q} == (len_q - 6'd1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          if (int'(len) > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            len_d     = len;
            crc_d     = 8'h00;
            idx_d     = 5'd0;
            busy_d    = 1'b1;
            state_d   = START;
            tx_wr_d   = 1'b1;
            tx_data_d = S3G_START;
          end
        end
      end
      START: begin
        if (accept) begin
          state_d   = LEN;
          tx_wr_d   = 1'b1;
          tx_data_d = {2'b00, len_q};
        end
      end
      LEN: begin
        if (accept) begin
          tx_wr_d = 1'b1;
          if (len_q == 6'd0) begin
            state_d   = CRC;
            tx_data_d = crc_q;
          end else begin
            state_d   = DATA;
            tx_data_d = rd_byte;
            crc_d     = crc_fold;
          end
        end
      end
      DATA: begin
        if (accept) begin
          tx_wr_d = 1'b1;
          if (last) begin
            state_d   = CRC;
            tx_data_d = crc_q;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_data_d = rd_byte;
            crc_d     = crc_fold;
          end
        end
      end
      CRC: begin
        if (accept) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= 6'd0;
      idx_q     <= 5'd0;
      crc_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign link.tx_wr   = tx_wr_q;
  assign link.tx_data = tx_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Bench for s3g_tx: directed frames from known CRC vectors plus random frames
// against a bit-serial CRC reference, with a UART model of random latency.
module tb_s3g_tx;
  import s3g_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, send;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] len;
  logic       busy, done, err;
  state_t     dbg_state;

  s3g_tx_if u_link ();

  s3g_tx #(.MAX_LEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .send      (send),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .link      (u_link),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] model_buf [32];
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, txd_cnt = 0, uart_cnt = 0;
  logic outstanding = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC: classic bit-serial Dallas form over the payload bits, LSB first.
  function automatic logic [7:0] crc_ref(input int n);
    logic [7:0] c, b;
    logic mix;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = model_buf[i];
      for (int k = 0; k < 8; k++) begin
        mix = c[0] ^ b[k];
        c   = c >> 1;
        if (mix) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  // ---------------- UART model ----------------
  initial begin
    u_link.tx_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      u_link.tx_done = 1'b0;
      if (u_link.tx_wr) begin
        uart_cnt = $urandom_range(1, 4);
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) u_link.tx_done = 1'b1;
      end else if (!busy && !rst && $urandom_range(0, 7) == 0) begin
        u_link.tx_done = 1'b1;  // stray pulse while idle must be ignored
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        outstanding = 1'b0;
      end else begin
        if (u_link.tx_done && outstanding) begin
          outstanding = 1'b0;
          txd_cnt++;
          check("byte_gap", {31'd0, u_link.tx_wr | done}, 32'd1);
        end
        if (u_link.tx_wr) begin
          check("wr_before_done", {31'd0, outstanding}, 32'd0);
          outstanding = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx_wr: got tx_data 0x%0h, required no write", u_link.tx_data);
          end else begin
            e = exp_q.pop_front();
            if (u_link.tx_data !== e) begin
              errors++;
              $display("FAIL tx_data: got 0x%0h, required 0x%0h", u_link.tx_data, e);
            end
          end
        end
        if (done) begin
          done_cnt++;
          check("done_all_bytes_sent", exp_q.size(), 32'd0);
        end
        if (err) err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d;
    model_buf[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input int n, input int crc_lit);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) exp_q.push_back(model_buf[i]);
    exp_q.push_back((crc_lit >= 0) ? 8'(crc_lit) : crc_ref(n));
  endtask

  task automatic run_frame(input int n, input int crc_lit, input bit disturb);
    int base_done, base_err, budget;
    base_done = done_cnt;
    base_err  = err_cnt;
    push_frame(n, crc_lit);
    send = 1'b1; len = 6'(n);
    tick();
    send = 1'b0;
    check("busy_after_send", {31'd0, busy}, 32'd1);
    budget = 0;
    while (done_cnt == base_done && budget < 1000) begin
      if (disturb && budget == 3) begin
        send = 1'b1; len = 6'd7;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = ~model_buf[0];
      end else begin
        send = 1'b0; wr_en = 1'b0;
      end
      tick();
      budget++;
    end
    send = 1'b0; wr_en = 1'b0;
    checks++;
    if (budget >= 1000) begin
      errors++;
      $display("FAIL frame_timeout: got no done after %0d cycles, required done (len=%0d)", budget, n);
    end
    tick();
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_count", done_cnt, base_done + 1);
    check("no_err_in_frame", err_cnt, base_err);
    check("exp_q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic reset_mid_frame(input int n);
    int base_txd, budget;
    base_txd = txd_cnt;
    push_frame(n, -1);
    send = 1'b1; len = 6'(n);
    tick();
    send = 1'b0;
    budget = 0;
    while (txd_cnt < base_txd + 2 && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL reset_wait_timeout: got %0d tx_done, required 2", txd_cnt - base_txd);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_tx_wr", {31'd0, u_link.tx_wr}, 32'd0);
    check("rst_mid_state", {29'd0, dbg_state}, {29'd0, IDLE});
    repeat (12) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1; send = 1'b0; len = 6'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h00;
    repeat (3) tick();
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_err",     {31'd0, err}, 32'd0);
    check("rst_tx_wr",   {31'd0, u_link.tx_wr}, 32'd0);
    check("rst_tx_data", {24'd0, u_link.tx_data}, 32'd0);
    check("rst_state",   {29'd0, dbg_state}, {29'd0, IDLE});
    rst = 1'b0;
    tick();

    write_byte(0, 8'h01);
    run_frame(1, 8'h5E, 1'b0);
    write_byte(0, 8'h81);
    run_frame(1, 8'hD2, 1'b0);
    write_byte(0, 8'h01);
    write_byte(1, 8'h01);
    run_frame(2, 8'h9A, 1'b0);
    run_frame(0, 8'h00, 1'b0);

    // over-length send is rejected with a single err pulse
    send = 1'b1; len = 6'd33;
    tick();
    send = 1'b0;
    check("err_pulse",      {31'd0, err}, 32'd1);
    check("err_busy_low",   {31'd0, busy}, 32'd0);
    tick();
    check("err_one_cycle",  {31'd0, err}, 32'd0);
    repeat (5) tick();

    for (int i = 0; i < 32; i++) write_byte(i, 8'(i));
    run_frame(32, -1, 1'b0);

    // send and buffer writes during a frame must not disturb it
    for (int i = 0; i < 4; i++) write_byte(i, 8'($urandom_range(0, 255)));
    run_frame(4, -1, 1'b1);
    run_frame(1, -1, 1'b0);

    for (int i = 0; i < 5; i++) write_byte(i, 8'($urandom_range(0, 255)));
    reset_mid_frame(5);
    run_frame(5, -1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(0, 32);
      for (int i = 0; i < n; i++) write_byte(i, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) tick();
      run_frame(n, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
